// File: rtl/stopwatch_pkg.sv
// Shared state encoding and elaboration helpers for the stopwatch/timer block.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_PROG  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/stopwatch_lap_fifo.sv
// Lap capture FIFO: full push with a same-cycle pop succeeds, otherwise a full push
// is dropped and flags a sticky overflow. Flush empties it and clears the flag.
module stopwatch_lap_fifo
   import stopwatch_pkg::*;
#(
   parameter int T_W       = 39,
   parameter int LAP_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_flush,
   input  logic           i_push,
   input  logic           i_pop,
   input  logic [T_W-1:0] i_data,
   output logic [T_W-1:0] o_data,
   output logic           o_valid,
   output logic           o_ovf
);

   localparam int AW = clog2(LAP_DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(LAP_DEPTH);

   logic [T_W-1:0] r_mem [LAP_DEPTH];
   logic [AW-1:0]  r_wp;
   logic [AW-1:0]  r_rp;
   logic [AW:0]    r_cnt;
   logic           r_ovf;
   logic           w_full;
   logic           w_empty;
   logic           w_do_push;
   logic           w_do_pop;

   assign w_full    = (r_cnt == CNT_FULL);
   assign w_empty   = (r_cnt == {(AW+1){1'b0}});
   assign w_do_pop  = i_pop & ~w_empty;
   assign w_do_push = i_push & (~w_full | w_do_pop);

   // Storage, pointers, occupancy and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAP_DEPTH; i++) begin
            r_mem[i] <= {T_W{1'b0}};
         end
         r_wp  <= {AW{1'b0}};
         r_rp  <= {AW{1'b0}};
         r_cnt <= {(AW+1){1'b0}};
         r_ovf <= 1'b0;
      end else if (i_flush) begin
         r_wp  <= {AW{1'b0}};
         r_rp  <= {AW{1'b0}};
         r_cnt <= {(AW+1){1'b0}};
         r_ovf <= 1'b0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wp] <= i_data;
            r_wp        <= r_wp + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rp <= r_rp + PTR_ONE;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + CNT_ONE;
            2'b01:   r_cnt <= r_cnt - CNT_ONE;
            default: r_cnt <= r_cnt;
         endcase
         if (i_push & ~w_do_push) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign o_data  = r_mem[r_rp];
   assign o_valid = ~w_empty;
   assign o_ovf   = r_ovf;

endmodule

// File: rtl/stopwatch_timer_ch.sv
// Count-up stopwatch / programmable count-down timer with explicit FSM.
// Optional lap capture FIFO is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_timer_ch
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int TICK_HZ    = 1000,
   parameter int T_W        = 39,
   parameter int SEC_TICKS  = 1000,
   parameter int MIN_TICKS  = 60000,
   parameter int PRESET_DEF = 60000,
   parameter int LAP_DEPTH  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           s,
   input  logic           p,
   input  logic           u,
   input  logic           clr,
   input  logic           inc,
   input  logic           min,
   input  logic           lap,
   input  logic           lap_rd,
   output logic [T_W-1:0] t,
   output logic           zero,
   output logic [2:0]     state,
   output logic [T_W-1:0] lap_t,
   output logic           lap_valid,
   output logic           lap_ovf
);

   localparam int DIV  = CLK_HZ / TICK_HZ;
   localparam int PS_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);
   localparam logic [PS_W-1:0] PS_ONE  = {{(PS_W-1){1'b0}}, 1'b1};
   localparam logic [T_W-1:0]  T_ZERO  = {T_W{1'b0}};
   localparam logic [T_W-1:0]  T_ONE   = {{(T_W-1){1'b0}}, 1'b1};
   localparam logic [T_W-1:0]  T_MAX   = {T_W{1'b1}};
   localparam logic [T_W-1:0]  SEC_STEP = T_W'(SEC_TICKS);
   localparam logic [T_W-1:0]  MIN_STEP = T_W'(MIN_TICKS);
   localparam logic [T_W-1:0]  PRE_RST  = T_W'(PRESET_DEF);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [T_W-1:0]  r_t;
   logic [T_W-1:0]  w_t_nxt;
   logic [T_W-1:0]  r_preset;
   logic [T_W-1:0]  w_preset_nxt;
   logic            r_dir;
   logic            w_dir_nxt;
   logic [PS_W-1:0] r_ps;
   logic [PS_W-1:0] w_ps_nxt;
   logic            r_zero;
   logic            r_s_q;
   logic            r_s_d;
   logic            r_inc_q;
   logic            r_inc_d;
   logic            w_s_edge;
   logic            w_inc_edge;
   logic [T_W-1:0]  w_reload;
   logic [T_W:0]    w_preset_sum;
   logic [T_W-1:0]  w_preset_inc;

   assign w_s_edge     = r_s_q & ~r_s_d;
   assign w_inc_edge   = r_inc_q & ~r_inc_d;
   assign w_reload     = u ? T_ZERO : r_preset;
   assign w_preset_sum = {1'b0, r_preset} + {1'b0, (min ? MIN_STEP : SEC_STEP)};
   assign w_preset_inc = w_preset_sum[T_W] ? T_MAX : w_preset_sum[T_W-1:0];

   // Input edge-detect history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s_q   <= 1'b0;
         r_s_d   <= 1'b0;
         r_inc_q <= 1'b0;
         r_inc_d <= 1'b0;
      end else begin
         r_s_q   <= s;
         r_s_d   <= r_s_q;
         r_inc_q <= inc;
         r_inc_d <= r_inc_q;
      end
   end

   // Next-state, time, preset and prescaler; p > clr > s edge > tick
   always_comb begin
      w_state_nxt  = r_state;
      w_t_nxt      = r_t;
      w_preset_nxt = r_preset;
      w_dir_nxt    = r_dir;
      w_ps_nxt     = r_ps;
      if (p) begin
         w_state_nxt = ST_PROG;
         if (r_state == ST_PROG) begin
            if (clr) begin
               w_preset_nxt = T_ZERO;
            end else if (w_inc_edge) begin
               w_preset_nxt = w_preset_inc;
            end else begin
               w_preset_nxt = r_preset;
            end
         end else begin
            w_preset_nxt = r_preset;
         end
      end else begin
         case (r_state)
            ST_PROG: begin
               w_state_nxt = ST_IDLE;
               w_t_nxt     = w_reload;
            end
            ST_IDLE: begin
               w_t_nxt = w_reload;
               if (clr) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_s_edge) begin
                  w_dir_nxt = u;
                  w_ps_nxt  = {PS_W{1'b0}};
                  // Zero-length countdown finishes without ever running
                  if (!u && (r_preset == T_ZERO)) begin
                     w_state_nxt = ST_DONE;
                     w_t_nxt     = T_ZERO;
                  end else begin
                     w_state_nxt = ST_RUN;
                  end
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (clr) begin
                  w_state_nxt = ST_IDLE;
                  w_t_nxt     = w_reload;
               end else if (w_s_edge) begin
                  w_state_nxt = ST_PAUSE;
               end else if (r_ps == PS_LAST) begin
                  w_ps_nxt = {PS_W{1'b0}};
                  if (r_dir) begin
                     w_t_nxt = (r_t == T_MAX) ? T_MAX : r_t + T_ONE;
                  end else if (r_t <= T_ONE) begin
                     w_t_nxt     = T_ZERO;
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_t_nxt = r_t - T_ONE;
                  end
               end else begin
                  w_ps_nxt = r_ps + PS_ONE;
               end
            end
            ST_PAUSE: begin
               if (clr) begin
                  w_state_nxt = ST_IDLE;
                  w_t_nxt     = w_reload;
               end else if (w_s_edge) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_PAUSE;
               end
            end
            ST_DONE: begin
               w_t_nxt = T_ZERO;
               if (clr) begin
                  w_state_nxt = ST_IDLE;
                  w_t_nxt     = w_reload;
               end else begin
                  w_state_nxt = ST_DONE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_t_nxt     = T_ZERO;
            end
         endcase
      end
   end

   // Architectural state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_t      <= T_ZERO;
         r_preset <= PRE_RST;
         r_dir    <= 1'b0;
         r_ps     <= {PS_W{1'b0}};
         r_zero   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_t      <= w_t_nxt;
         r_preset <= w_preset_nxt;
         r_dir    <= w_dir_nxt;
         r_ps     <= w_ps_nxt;
         r_zero   <= (w_state_nxt == ST_DONE);
      end
   end

   assign t     = r_t;
   assign zero  = r_zero;
   assign state = r_state;

`ifdef STOPWATCH_LAP_EN
   logic r_lap_q;
   logic r_lap_d;
   logic w_lap_push;
   logic w_lap_pop;

   // Lap edge-detect history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lap_q <= 1'b0;
         r_lap_d <= 1'b0;
      end else begin
         r_lap_q <= lap;
         r_lap_d <= r_lap_q;
      end
   end

   assign w_lap_push = r_lap_q & ~r_lap_d & ((r_state == ST_RUN) | (r_state == ST_PAUSE));
   assign w_lap_pop  = lap_rd & lap_valid;

   stopwatch_lap_fifo #(
      .T_W       (T_W),
      .LAP_DEPTH (LAP_DEPTH)
   ) u_lap_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (clr),
      .i_push  (w_lap_push),
      .i_pop   (w_lap_pop),
      .i_data  (r_t),
      .o_data  (lap_t),
      .o_valid (lap_valid),
      .o_ovf   (lap_ovf)
   );
`else
   logic w_unused_lap;
   assign w_unused_lap = &{1'b0, lap, lap_rd};
   assign lap_t        = T_ZERO;
   assign lap_valid    = 1'b0;
   assign lap_ovf      = 1'b0;
`endif

endmodule
